// File: rtl/sh7604_ext_bus_responder_pkg.sv
// rtl/sh7604_ext_bus_responder_pkg.sv - shared types and constants for the SH7604 external bus responder
package sh7604_ext_bus_responder_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_REQ = 2'd1,
      DONE     = 2'd2
   } bus_state_t;

   localparam logic [31:0] CPU_DI_TIMEOUT = 32'hFFFF_FFFF;
   localparam int          CNT_W          = 8;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/sh7604_ext_bus_responder.sv
// rtl/sh7604_ext_bus_responder.sv - SH7604 chip-select area slave converting bus cycles into req/ack transactions
module sh7604_ext_bus_responder
   import sh7604_ext_bus_responder_pkg::*;
#(
   parameter int ADDR_W   = 20,
   parameter int MIN_WAIT = 1,
   parameter int TIMEOUT  = 255
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              CE_R,
   input  logic              CE_F,
   input  logic [26:0]       A,
   input  logic [31:0]       CPU_DO,
   output logic [31:0]       CPU_DI,
   input  logic              BS_N,
   input  logic              CS_N,
   input  logic              RD_WR_N,
   input  logic [3:0]        WE_N,
   input  logic              RD_N,
   output logic              WAIT_N,
   output logic [ADDR_W-1:0] MEM_A,
   output logic [31:0]       MEM_DO,
   input  logic [31:0]       MEM_DI,
   output logic [3:0]        MEM_BE,
   output logic              MEM_WR,
   output logic              MEM_REQ,
   input  logic              MEM_ACK,
   output logic              ERR
);

   localparam logic [CNT_W:0] MIN_WAIT_C = (CNT_W+1)'(MIN_WAIT);
   localparam logic [CNT_W:0] TIMEOUT_C  = (CNT_W+1)'(TIMEOUT);

   bus_state_t       state;
   logic [CNT_W-1:0] wait_cnt;
   logic             ack_seen;
   logic [31:0]      ack_data;

   logic             start;
   logic             ack_now;
   logic             min_met;
   logic             tmo_hit;
   logic [CNT_W:0]   cnt_p1;
   logic             unused_pins;

   // RD_N may trail BS_N, so reads are accepted on BS_N alone
   assign unused_pins = ^{CE_F, RD_N, A[26:ADDR_W]};

   assign start   = !CS_N && !BS_N && (state != WAIT_REQ);
   assign cnt_p1  = {1'b0, wait_cnt} + (CNT_W+1)'(1);
   assign ack_now = MEM_ACK || ack_seen;
   assign min_met = cnt_p1 >= MIN_WAIT_C;
   assign tmo_hit = cnt_p1 >= TIMEOUT_C;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state    <= IDLE;
         wait_cnt <= '0;
         ack_seen <= 1'b0;
         ack_data <= '0;
         CPU_DI   <= '0;
         WAIT_N   <= 1'b1;
         MEM_A    <= '0;
         MEM_DO   <= '0;
         MEM_BE   <= '0;
         MEM_WR   <= 1'b0;
         MEM_REQ  <= 1'b0;
         ERR      <= 1'b0;
      end else if (CE_R) begin
         ERR <= 1'b0;
         if (start) begin
            MEM_A    <= A[ADDR_W-1:0];
            MEM_WR   <= !RD_WR_N;
            if (!RD_WR_N) begin
               MEM_DO <= CPU_DO;
               MEM_BE <= ~WE_N;
            end else begin
               MEM_BE <= 4'hF;
            end
            MEM_REQ  <= 1'b1;
            WAIT_N   <= 1'b0;
            wait_cnt <= '0;
            ack_seen <= 1'b0;
            state    <= WAIT_REQ;
         end else begin
            case (state)
               WAIT_REQ: begin
                  if (CS_N) begin
                     MEM_REQ <= 1'b0;
                     WAIT_N  <= 1'b1;
                     state   <= IDLE;
                  end else begin
                     wait_cnt <= sat_inc(wait_cnt);
                     // first ACK's data is held until the wait floor is met
                     if (MEM_ACK && !ack_seen) begin
                        ack_seen <= 1'b1;
                        ack_data <= MEM_DI;
                     end
                     if (ack_now && min_met) begin
                        if (!MEM_WR) CPU_DI <= ack_seen ? ack_data : MEM_DI;
                        MEM_REQ <= 1'b0;
                        WAIT_N  <= 1'b1;
                        state   <= DONE;
                     end else if (!ack_now && tmo_hit) begin
                        if (!MEM_WR) CPU_DI <= CPU_DI_TIMEOUT;
                        MEM_REQ <= 1'b0;
                        WAIT_N  <= 1'b1;
                        ERR     <= 1'b1;
                        state   <= DONE;
                     end
                  end
               end
               DONE: begin
                  if (CS_N) state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sh7604_ext_bus_responder.sv
// tb/tb_sh7604_ext_bus_responder.sv - directed self-checking bench for sh7604_ext_bus_responder
module tb_sh7604_ext_bus_responder;
   import sh7604_ext_bus_responder_pkg::*;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        CE_R = 1'b0;
   logic        CE_F = 1'b0;
   logic [26:0] A = '0;
   logic [31:0] CPU_DO = '0;
   logic        BS_N = 1'b1;
   logic        CS_N = 1'b1;
   logic        RD_WR_N = 1'b1;
   logic [3:0]  WE_N = 4'hF;
   logic        RD_N = 1'b1;
   logic [31:0] MEM_DI = '0;
   logic        MEM_ACK = 1'b0;

   logic [31:0] a_cpu_di, b_cpu_di, a_mem_do, b_mem_do;
   logic [19:0] a_mem_a, b_mem_a;
   logic [3:0]  a_mem_be, b_mem_be;
   logic        a_wait_n, b_wait_n, a_mem_wr, b_mem_wr, a_mem_req, b_mem_req, a_err, b_err;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;
   always @(negedge CLK) begin
      CE_R = ~CE_R;
      CE_F = ~CE_R;
   end

   sh7604_ext_bus_responder #(.ADDR_W(20), .MIN_WAIT(1), .TIMEOUT(8)) dut_a (
      .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .CE_F(CE_F), .A(A), .CPU_DO(CPU_DO),
      .CPU_DI(a_cpu_di), .BS_N(BS_N), .CS_N(CS_N), .RD_WR_N(RD_WR_N), .WE_N(WE_N),
      .RD_N(RD_N), .WAIT_N(a_wait_n), .MEM_A(a_mem_a), .MEM_DO(a_mem_do), .MEM_DI(MEM_DI),
      .MEM_BE(a_mem_be), .MEM_WR(a_mem_wr), .MEM_REQ(a_mem_req), .MEM_ACK(MEM_ACK), .ERR(a_err)
   );

   sh7604_ext_bus_responder #(.ADDR_W(20), .MIN_WAIT(5), .TIMEOUT(255)) dut_b (
      .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .CE_F(CE_F), .A(A), .CPU_DO(CPU_DO),
      .CPU_DI(b_cpu_di), .BS_N(BS_N), .CS_N(CS_N), .RD_WR_N(RD_WR_N), .WE_N(WE_N),
      .RD_N(RD_N), .WAIT_N(b_wait_n), .MEM_A(b_mem_a), .MEM_DO(b_mem_do), .MEM_DI(MEM_DI),
      .MEM_BE(b_mem_be), .MEM_WR(b_mem_wr), .MEM_REQ(b_mem_req), .MEM_ACK(MEM_ACK), .ERR(b_err)
   );

   task automatic ce_step();
      do @(posedge CLK); while (CE_R !== 1'b1);
      #1;
   endtask

   task automatic idle_bus(input int n);
      CS_N = 1'b1; BS_N = 1'b1; MEM_ACK = 1'b0; RD_N = 1'b1;
      for (int i = 0; i < n; i++) ce_step();
   endtask

   task automatic test_reset();
      ce_step();
      ce_step();
      checks++; if (a_wait_n !== 1'b1) begin errors++; $display("FAIL reset_wait_n got %b want 1", a_wait_n); end
      checks++; if (a_mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b want 0", a_mem_req); end
      checks++; if (a_mem_wr !== 1'b0) begin errors++; $display("FAIL reset_mem_wr got %b want 0", a_mem_wr); end
      checks++; if (a_mem_be !== 4'h0) begin errors++; $display("FAIL reset_mem_be got %h want 0", a_mem_be); end
      checks++; if (a_mem_a !== 20'h0) begin errors++; $display("FAIL reset_mem_a got %h want 0", a_mem_a); end
      checks++; if (a_mem_do !== 32'h0) begin errors++; $display("FAIL reset_mem_do got %h want 0", a_mem_do); end
      checks++; if (a_cpu_di !== 32'h0) begin errors++; $display("FAIL reset_cpu_di got %h want 0", a_cpu_di); end
      checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", a_err); end
      #3 RST_N = 1'b1;
      idle_bus(2);
   endtask

   task automatic test_read();
      int low;
      CS_N = 1'b0; BS_N = 1'b0; RD_WR_N = 1'b1; RD_N = 1'b1; A = 27'h0001234;
      ce_step();
      checks++; if (a_wait_n !== 1'b0) begin errors++; $display("FAIL read_wait_low got %b want 0", a_wait_n); end
      checks++; if (a_mem_req !== 1'b1) begin errors++; $display("FAIL read_req got %b want 1", a_mem_req); end
      checks++; if (a_mem_be !== 4'hF) begin errors++; $display("FAIL read_be got %h want f", a_mem_be); end
      checks++; if (a_mem_wr !== 1'b0) begin errors++; $display("FAIL read_wr got %b want 0", a_mem_wr); end
      BS_N = 1'b1; RD_N = 1'b0; A = 27'h7FFFFFF;
      low = 1;
      for (int k = 1; k <= 20 && a_wait_n === 1'b0; k++) begin
         MEM_ACK = (k == 4);
         MEM_DI  = (k == 4) ? 32'hDEADBEEF : 32'h0;
         ce_step();
         if (a_wait_n === 1'b0) low++;
      end
      MEM_ACK = 1'b0;
      checks++; if (low != 4) begin errors++; $display("FAIL read_wait_len got %0d want 4", low); end
      checks++; if (a_cpu_di !== 32'hDEADBEEF) begin errors++; $display("FAIL read_data got %h want deadbeef", a_cpu_di); end
      checks++; if (a_mem_req !== 1'b0) begin errors++; $display("FAIL read_req_drop got %b want 0", a_mem_req); end
      checks++; if (a_mem_a !== 20'h01234) begin errors++; $display("FAIL read_addr got %h want 01234", a_mem_a); end
      idle_bus(3);
   endtask

   task automatic test_write();
      int req_cycles;
      CS_N = 1'b0; BS_N = 1'b0; RD_WR_N = 1'b0; WE_N = 4'b1101; CPU_DO = 32'h00AA0000; A = 27'h0000100;
      ce_step();
      checks++; if (a_mem_wr !== 1'b1) begin errors++; $display("FAIL write_wr got %b want 1", a_mem_wr); end
      checks++; if (a_mem_be !== 4'b0010) begin errors++; $display("FAIL write_be got %b want 0010", a_mem_be); end
      BS_N = 1'b1; WE_N = 4'hF; CPU_DO = 32'h12121212;
      req_cycles = 1;
      for (int k = 1; k <= 20 && a_mem_req === 1'b1; k++) begin
         MEM_ACK = (k == 1);
         MEM_DI  = 32'h55555555;
         ce_step();
         if (a_mem_req === 1'b1) req_cycles++;
      end
      MEM_ACK = 1'b0;
      checks++; if (req_cycles != 1) begin errors++; $display("FAIL write_req_len got %0d want 1", req_cycles); end
      checks++; if (a_mem_do !== 32'h00AA0000) begin errors++; $display("FAIL write_data got %h want 00aa0000", a_mem_do); end
      checks++; if (a_cpu_di !== 32'hDEADBEEF) begin errors++; $display("FAIL write_cpu_di got %h want deadbeef", a_cpu_di); end
      RD_WR_N = 1'b1;
      idle_bus(3);
   endtask

   task automatic test_early_ack();
      int low;
      CS_N = 1'b0; BS_N = 1'b0; RD_WR_N = 1'b1; A = 27'h0000010;
      ce_step();
      BS_N = 1'b1;
      low = 1;
      for (int k = 1; k <= 20 && b_wait_n === 1'b0; k++) begin
         MEM_ACK = (k == 1);
         MEM_DI  = (k == 1) ? 32'h12345678 : 32'h0;
         ce_step();
         if (b_wait_n === 1'b0) low++;
      end
      MEM_ACK = 1'b0;
      checks++; if (low != 5) begin errors++; $display("FAIL early_wait_len got %0d want 5", low); end
      checks++; if (b_cpu_di !== 32'h12345678) begin errors++; $display("FAIL early_data got %h want 12345678", b_cpu_di); end
      idle_bus(3);
   endtask

   task automatic test_timeout();
      int low;
      CS_N = 1'b0; BS_N = 1'b0; RD_WR_N = 1'b1; A = 27'h0000020;
      ce_step();
      BS_N = 1'b1;
      low = 1;
      for (int k = 1; k <= 20 && a_wait_n === 1'b0; k++) begin
         ce_step();
         if (a_wait_n === 1'b0) low++;
      end
      checks++; if (low != 8) begin errors++; $display("FAIL tmo_wait_len got %0d want 8", low); end
      checks++; if (a_err !== 1'b1) begin errors++; $display("FAIL tmo_err_high got %b want 1", a_err); end
      checks++; if (a_cpu_di !== 32'hFFFFFFFF) begin errors++; $display("FAIL tmo_data got %h want ffffffff", a_cpu_di); end
      MEM_ACK = 1'b1; MEM_DI = 32'h11111111;
      ce_step();
      MEM_ACK = 1'b0;
      checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL tmo_err_pulse got %b want 0", a_err); end
      checks++; if (a_cpu_di !== 32'hFFFFFFFF) begin errors++; $display("FAIL tmo_late_ack got %h want ffffffff", a_cpu_di); end
      checks++; if (a_mem_req !== 1'b0) begin errors++; $display("FAIL tmo_req got %b want 0", a_mem_req); end
      idle_bus(3);
   endtask

   task automatic test_abort();
      CS_N = 1'b0; BS_N = 1'b0; RD_WR_N = 1'b1; A = 27'h0000030;
      ce_step();
      BS_N = 1'b1;
      ce_step();
      ce_step();
      CS_N = 1'b1; MEM_ACK = 1'b1; MEM_DI = 32'hCAFEF00D;
      ce_step();
      MEM_ACK = 1'b0;
      checks++; if (a_mem_req !== 1'b0) begin errors++; $display("FAIL abort_req got %b want 0", a_mem_req); end
      checks++; if (a_wait_n !== 1'b1) begin errors++; $display("FAIL abort_wait_n got %b want 1", a_wait_n); end
      checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL abort_err got %b want 0", a_err); end
      checks++; if (dut_a.state !== IDLE) begin errors++; $display("FAIL abort_state got %0d want 0", dut_a.state); end
      checks++; if (a_cpu_di !== 32'hFFFFFFFF) begin errors++; $display("FAIL abort_data got %h want ffffffff", a_cpu_di); end
      idle_bus(3);
   endtask

   task automatic test_back_to_back();
      CS_N = 1'b0; BS_N = 1'b0; RD_WR_N = 1'b1; A = 27'h0000040;
      ce_step();
      BS_N = 1'b1; MEM_ACK = 1'b1; MEM_DI = 32'hA5A5A5A5;
      ce_step();
      MEM_ACK = 1'b0;
      checks++; if (a_wait_n !== 1'b1) begin errors++; $display("FAIL b2b_first_done got %b want 1", a_wait_n); end
      BS_N = 1'b0; A = 27'h0000044;
      ce_step();
      checks++; if (a_mem_req !== 1'b1) begin errors++; $display("FAIL b2b_second_req got %b want 1", a_mem_req); end
      checks++; if (a_mem_a !== 20'h00044) begin errors++; $display("FAIL b2b_addr got %h want 00044", a_mem_a); end
      checks++; if (a_cpu_di !== 32'hA5A5A5A5) begin errors++; $display("FAIL b2b_hold got %h want a5a5a5a5", a_cpu_di); end
      BS_N = 1'b1; MEM_ACK = 1'b1; MEM_DI = 32'h5A5A5A5A;
      ce_step();
      MEM_ACK = 1'b0;
      checks++; if (a_cpu_di !== 32'h5A5A5A5A) begin errors++; $display("FAIL b2b_second_data got %h want 5a5a5a5a", a_cpu_di); end
      BS_N = 1'b0; A = 27'h0000048;
      ce_step();
      BS_N = 1'b1;
      checks++; if (a_mem_req !== 1'b1) begin errors++; $display("FAIL rst_pre_req got %b want 1", a_mem_req); end
      #3 RST_N = 1'b0;
      #1;
      checks++; if (a_mem_req !== 1'b0) begin errors++; $display("FAIL rst_mid_req got %b want 0", a_mem_req); end
      checks++; if (a_wait_n !== 1'b1) begin errors++; $display("FAIL rst_mid_wait_n got %b want 1", a_wait_n); end
      checks++; if (a_cpu_di !== 32'h0) begin errors++; $display("FAIL rst_mid_cpu_di got %h want 0", a_cpu_di); end
      checks++; if (a_mem_a !== 20'h0) begin errors++; $display("FAIL rst_mid_mem_a got %h want 0", a_mem_a); end
      checks++; if (a_mem_be !== 4'h0) begin errors++; $display("FAIL rst_mid_mem_be got %h want 0", a_mem_be); end
      #2 RST_N = 1'b1;
      idle_bus(2);
   endtask

   initial begin
      test_reset();
      test_read();
      test_write();
      test_early_ack();
      test_timeout();
      test_abort();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
